// File: rtl/vga_timing_generator.sv
// 640x480@60 VGA raster timing: pixel-rate divider, column/line counters,
// sync/blank decode delayed to line up with video memory read latency, and
// registered DAC-side outputs (grayscale RGB, syncs, blank, pixel clock).
module vga_timing_generator #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pixel_data,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       pixel_tick,
  output logic       frame_start,
  output logic       vga_clk,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEGIN = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       hcnt_q, hcnt_d;
  logic [9:0]       vcnt_q, vcnt_d;
  logic             frame_start_q, frame_start_d;
  logic             vga_clk_q, vga_clk_d;

  logic                  hs_raw, vs_raw, active_raw;
  logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
  logic [PIPE_DELAY-1:0] act_pipe_q, act_pipe_d;
  logic [PIPE_DELAY:0]   hs_shift, vs_shift, act_shift;

  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       blank_n_q, blank_n_d;
  logic [7:0] rgb_q, rgb_d;

  assign pixel_tick  = (div_cnt_q == DIV_LAST);
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign frame_start = frame_start_q;
  assign vga_clk     = vga_clk_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign vga_r       = rgb_q;
  assign vga_g       = rgb_q;
  assign vga_b       = rgb_q;

  // Divider, raster counters, frame pulse and mid-pixel DAC clock
  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    if (pixel_tick) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
    frame_start_d = pixel_tick && (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
    vga_clk_d = vga_clk_q;
    if (div_cnt_d == DIV_HALF) begin
      vga_clk_d = 1'b1;
    end else if (div_cnt_d == '0) begin
      vga_clk_d = 1'b0;
    end
  end

  // Raw sync/active decode from the current coordinate
  always_comb begin
    hs_raw     = !((hcnt_q >= HS_BEGIN) && (hcnt_q < HS_END));
    vs_raw     = !((vcnt_q >= VS_BEGIN) && (vcnt_q < VS_END));
    active_raw = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
  end

  // Delay line matching memory latency; the concatenate-then-slice form
  // keeps a single-stage line legal without special-casing it
  always_comb begin
    hs_shift   = {hs_pipe_q, hs_raw};
    vs_shift   = {vs_pipe_q, vs_raw};
    act_shift  = {act_pipe_q, active_raw};
    hs_pipe_d  = hs_pipe_q;
    vs_pipe_d  = vs_pipe_q;
    act_pipe_d = act_pipe_q;
    if (pixel_tick) begin
      hs_pipe_d  = hs_shift[PIPE_DELAY-1:0];
      vs_pipe_d  = vs_shift[PIPE_DELAY-1:0];
      act_pipe_d = act_shift[PIPE_DELAY-1:0];
    end
  end

  // Output stage fed from the last delay stage and the returned pixel
  always_comb begin
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;
    if (pixel_tick) begin
      hsync_d   = hs_pipe_q[PIPE_DELAY-1];
      vsync_d   = vs_pipe_q[PIPE_DELAY-1];
      blank_n_d = act_pipe_q[PIPE_DELAY-1];
      rgb_d     = act_pipe_q[PIPE_DELAY-1] ? pixel_data : '0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      frame_start_q <= 1'b0;
      vga_clk_q     <= 1'b0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
      act_pipe_q    <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_n_q     <= 1'b0;
      rgb_q         <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      frame_start_q <= frame_start_d;
      vga_clk_q     <= vga_clk_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      act_pipe_q    <= act_pipe_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_n_q     <= blank_n_d;
      rgb_q         <= rgb_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench for vga_timing_generator on a shrunken raster.
// Expected outputs come from tick-index arithmetic; a memory model answers
// the DUT's presented coordinates with PD-tick latency.
module tb_vga_timing_generator;

  localparam int HV = 16, HF = 4, HSW = 6, HB = 4;
  localparam int VV = 8,  VF = 2, VSW = 2, VB = 3;
  localparam int CD = 2,  PD = 2;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pixel_data = 8'h00;
  logic [9:0] hcnt, vcnt;
  logic       pixel_tick, frame_start, vga_clk;
  logic       vga_hsync, vga_vsync, vga_blank_n, vga_sync_n;
  logic [7:0] vga_r, vga_g, vga_b;

  vga_timing_generator #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .CLK_DIV(CD), .PIPE_DELAY(PD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel_data(pixel_data),
    .hcnt(hcnt), .vcnt(vcnt), .pixel_tick(pixel_tick),
    .frame_start(frame_start), .vga_clk(vga_clk),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hs;
    logic       vs;
    logic       bl;
    logic [7:0] rgb;
    logic       fs;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         running = 1'b0;
  int         mode = 0;
  logic [7:0] fb [0:VT-1][0:HT-1];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      if (errors <= 25)
        $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Memory contents: mode 0 column ramp, mode 1 all-white, mode 2 random image
  function automatic logic [7:0] mem_val(input int h, input int v);
    if (mode == 0) return 8'(h);
    if (mode == 1) return 8'hFF;
    return fb[v][h];
  endfunction

  task automatic reset_checks();
    chk("rst_hcnt", int'(hcnt), 0);
    chk("rst_vcnt", int'(vcnt), 0);
    chk("rst_pixel_tick", int'(pixel_tick), 0);
    chk("rst_hsync", int'(vga_hsync), 1);
    chk("rst_vsync", int'(vga_vsync), 1);
    chk("rst_blank_n", int'(vga_blank_n), 0);
    chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
    chk("rst_vga_clk", int'(vga_clk), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_sync_n", int'(vga_sync_n), 0);
  endtask

  initial begin
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++)
        fb[v][h] = 8'($urandom);

    fork
      // Stimulus / memory model: per tick, verify the presented coordinate,
      // answer the one from PD ticks ago, push the expected output response
      begin : stim
        int k;
        int hist_h[$];
        int hist_v[$];
        int h, v, kk, eh, ev;
        exp_t x;
        logic act;
        k = 0;
        forever begin
          @(negedge clk);
          if (!running) begin
            k = 0;
            hist_h.delete();
            hist_v.delete();
            exp_q.delete();
          end else if (pixel_tick) begin
            h = k % HT;
            v = (k / HT) % VT;
            chk("hcnt", int'(hcnt), h);
            chk("vcnt", int'(vcnt), v);
            hist_h.push_back(int'(hcnt));
            hist_v.push_back(int'(vcnt));
            if (hist_h.size() > PD) begin
              pixel_data = mem_val(hist_h.pop_front(), hist_v.pop_front());
            end else begin
              pixel_data = 8'($urandom);
            end
            if (k < PD) begin
              x.hs = 1'b1; x.vs = 1'b1; x.bl = 1'b0; x.rgb = 8'h00;
            end else begin
              kk  = k - PD;
              eh  = kk % HT;
              ev  = (kk / HT) % VT;
              act = (eh < HV) && (ev < VV);
              x.hs  = !((eh >= HV + HF) && (eh < HV + HF + HSW));
              x.vs  = !((ev >= VV + VF) && (ev < VV + VF + VSW));
              x.bl  = act;
              x.rgb = act ? mem_val(eh, ev) : 8'h00;
            end
            x.fs = ((k % FT) == FT - 1);
            exp_q.push_back(x);
            k++;
          end
        end
      end

      // Monitor: checks clock-phase signals every cycle and pops one
      // expectation after each pixel-tick edge
      begin : mon
        int e;
        int fs_exp;
        exp_t y;
        e = 0;
        forever begin
          @(negedge clk);
          if (!running) begin
            e = 0;
          end else begin
            e++;
            fs_exp = 0;
            chk("pixel_tick", int'(pixel_tick), int'((e % CD) == CD - 1));
            chk("vga_clk", int'(vga_clk), int'((e % CD) >= CD / 2));
            chk("vga_sync_n", int'(vga_sync_n), 0);
            if ((e % CD) == 0) begin
              if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty actual=0 entries required=1 at %0t", $time);
              end else begin
                y = exp_q.pop_front();
                chk("vga_hsync", int'(vga_hsync), int'(y.hs));
                chk("vga_vsync", int'(vga_vsync), int'(y.vs));
                chk("vga_blank_n", int'(vga_blank_n), int'(y.bl));
                chk("vga_r", int'(vga_r), int'(y.rgb));
                chk("vga_g", int'(vga_g), int'(y.rgb));
                chk("vga_b", int'(vga_b), int'(y.rgb));
                fs_exp = int'(y.fs);
              end
            end
            chk("frame_start", int'(frame_start), fs_exp);
          end
        end
      end
    join_none

    // Power-on reset, then column-ramp memory over two full frames
    mode = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks();
    #2 rst_n = 1'b1;
    running = 1'b1;
    repeat (2 * FT * CD + 40) @(negedge clk);

    // Asynchronous reset mid-frame, away from any clock edge
    repeat ($urandom_range(100, 600)) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    running = 1'b0;
    #1 reset_checks();
    mode = 1;
    repeat (5) @(negedge clk);
    reset_checks();
    #2 rst_n = 1'b1;
    running = 1'b1;

    // All-white memory: RGB must still be zero throughout blanking
    repeat (FT * CD + 2 * HT * CD) @(negedge clk);

    // Random image, switched on the fly
    mode = 2;
    repeat (FT * CD + 100) @(negedge clk);

    running = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
